// File: rtl/dct_block_scheduler.sv
// Walks every 8x8 block of the luma buffer in raster order, fetches 64 pixels into a 512-bit MCU
// and hands it to the DCT stage. Optional stall counter is built when DCT_SCHED_STALL_CNT_EN is defined.
module dct_block_scheduler #(
  parameter int IMG_W = 224,
  parameter int IMG_H = 224,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          freeze_img,
  output logic          pix_rd_en,
  output logic [AW-1:0] pix_rd_addr,
  input  logic [7:0]    pix_rd_data,
  output logic [511:0]  mcu,
  output logic          mcu_valid,
  input  logic          mcu_ready,
  output logic [7:0]    blk_x,
  output logic [7:0]    blk_y,
  output logic [31:0]   stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_FIN} state_e;

  localparam logic [7:0]    LAST_X     = 8'(IMG_W / 8 - 1);
  localparam logic [7:0]    LAST_Y     = 8'(IMG_H / 8 - 1);
  localparam logic [AW-1:0] IMG_W_A    = AW'(IMG_W);
  localparam logic [6:0]    FETCH_LAST = 7'd64;

  state_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [7:0]    blk_x_q, blk_x_d;
  logic [7:0]    blk_y_q, blk_y_d;
  logic [511:0]  mcu_q;
  logic          start_acc, handshake, last_blk, cap_en;
  logic [5:0]    cap_idx;
  logic [AW-1:0] row_a, col_a;

  assign start_acc = (state_q == S_IDLE) && start;
  assign handshake = (state_q == S_EMIT) && mcu_ready;
  assign last_blk  = (blk_x_q == LAST_X) && (blk_y_q == LAST_Y);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_x_d = blk_x_q;
    blk_y_d = blk_y_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          blk_x_d = '0;
          blk_y_d = '0;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == FETCH_LAST) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (handshake) begin
          cnt_d = '0;
          if (last_blk) begin
            state_d = S_FIN;
          end else begin
            state_d = S_FETCH;
            if (blk_x_q == LAST_X) begin
              blk_x_d = '0;
              blk_y_d = blk_y_q + 8'd1;
            end else begin
              blk_x_d = blk_x_q + 8'd1;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      blk_x_q <= '0;
      blk_y_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_x_q <= blk_x_d;
      blk_y_q <= blk_y_d;
    end
  end

  // Read k is issued at cnt=k; its byte returns one cycle later and lands in slot k.
  assign cap_en  = (state_q == S_FETCH) && (cnt_q != 7'd0);
  assign cap_idx = 6'(cnt_q - 7'd1);

  // NOTE: the MCU register is reset because it is a visible output that must read zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcu_q <= '0;
    end else if (cap_en) begin
      mcu_q[8*cap_idx +: 8] <= pix_rd_data;
    end
  end

  // {blk, r} and {blk, c} are blk*8+r and blk*8+c without explicit multipliers.
  assign row_a = AW'({blk_y_q, cnt_q[5:3]});
  assign col_a = AW'({blk_x_q, cnt_q[2:0]});

  assign pix_rd_en   = (state_q == S_FETCH) && !cnt_q[6];
  assign pix_rd_addr = pix_rd_en ? (row_a * IMG_W_A + col_a) : '0;

  assign busy       = (state_q == S_FETCH) || (state_q == S_EMIT);
  assign freeze_img = busy;
  assign done       = (state_q == S_FIN);
  assign mcu_valid  = (state_q == S_EMIT);
  assign mcu        = mcu_q;
  assign blk_x      = blk_x_q;
  assign blk_y      = blk_y_q;

`ifdef DCT_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if ((state_q == S_EMIT) && !mcu_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Self-checking bench for dct_block_scheduler: reset, mid-frame abort and a full frame with
// randomized back-pressure, checked against a block-level model of the raster walk.
module tb_dct_block_scheduler;

  localparam int IMG_W   = 224;
  localparam int IMG_H   = 224;
  localparam int AW      = 16;
  localparam int NBX     = IMG_W / 8;
  localparam int NBY     = IMG_H / 8;
  localparam int NBLK    = NBX * NBY;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int BLK_CYC = 66;

`ifdef DCT_SCHED_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, freeze_img, pix_rd_en, mcu_valid;
  logic [AW-1:0] pix_rd_addr;
  logic [7:0]    pix_rd_data = 8'h00;
  logic [511:0]  mcu;
  logic          mcu_ready = 1'b0;
  logic [7:0]    blk_x, blk_y;
  logic [31:0]   stall_cycles;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [NPIX];
  int         stall_plan [NBLK];

  dct_block_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .freeze_img   (freeze_img),
    .pix_rd_en    (pix_rd_en),
    .pix_rd_addr  (pix_rd_addr),
    .pix_rd_data  (pix_rd_data),
    .mcu          (mcu),
    .mcu_valid    (mcu_valid),
    .mcu_ready    (mcu_ready),
    .blk_x        (blk_x),
    .blk_y        (blk_y),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Pixel RAM: one-cycle read latency; garbage on idle cycles exposes mistimed captures.
  always @(posedge clk) begin
    if (pix_rd_en && int'(pix_rd_addr) < NPIX) pix_rd_data <= ram[int'(pix_rd_addr)];
    else pix_rd_data <= 8'($urandom);
  end

  function automatic logic [511:0] exp_block(int bx, int by);
    logic [511:0] v;
    v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        v[8*(r*8+c) +: 8] = ram[(by*8 + r)*IMG_W + bx*8 + c];
    return v;
  endfunction

  function automatic int exp_addr(int b, int i);
    return ((b / NBX)*8 + i / 8)*IMG_W + (b % NBX)*8 + i % 8;
  endfunction

  function automatic logic [31:0] exp_stall(int n);
    return STALL_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic test_reset;
    logic bad;
    reset_n = 1'b0; start = 1'b0; mcu_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, freeze_img, pix_rd_en, mcu_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, freeze_img, pix_rd_en, mcu_valid});
    end
    checks++;
    if (pix_rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", pix_rd_addr); end
    checks++;
    if (mcu !== '0) begin errors++; $display("FAIL reset_mcu: got %h expected 0", mcu); end
    checks++;
    if ({blk_x, blk_y} !== 16'h0) begin errors++; $display("FAIL reset_blk: got %h expected 0000", {blk_x, blk_y}); end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mcu_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy !== 1'b0 || mcu_valid !== 1'b0 || pix_rd_en !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_quiet: got activity expected none while idle with mcu_ready toggling"); end
  endtask

  task automatic test_reset_mid_frame;
    int k, cyc, target;
    logic saw_done;
    target = $urandom_range(2, 60);
    k = 0; cyc = 0; saw_done = 1'b0;
    @(negedge clk); start = 1'b1; mcu_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (k < target && cyc < 143*BLK_CYC + 200) begin
      @(negedge clk);
      cyc++;
      if (done) saw_done = 1'b1;
      if (blk_x == 8'd3 && blk_y == 8'd5 && pix_rd_en) k++;
      mcu_ready = mcu_valid ? 1'b1 : 1'($urandom_range(0, 1));
    end
    checks++;
    if (k != target) begin errors++; $display("FAIL reach_blk_3_5: got %0d reads expected %0d", k, target); end
    checks++;
    if (saw_done) begin errors++; $display("FAIL early_done: got done pulse expected none before block (3,5)"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, freeze_img, mcu_valid, pix_rd_en, done} !== 5'b0) begin
      errors++; $display("FAIL async_reset: got %b expected 00000", {busy, freeze_img, mcu_valid, pix_rd_en, done});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, mcu_valid, pix_rd_en, done} !== 4'b0 || {blk_x, blk_y} !== 16'h0) begin
      errors++; $display("FAIL reset_edge: got ctrl=%b blk=%h expected 0000/0000", {busy, mcu_valid, pix_rd_en, done}, {blk_x, blk_y});
    end
    @(negedge clk); reset_n = 1'b1; mcu_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_frame;
    int b, wait_n, cyc, done_cyc, done_cnt, rd_i, total, cum, limit, extra_done;
    logic [511:0] snap_mcu, exp_mcu;
    logic [7:0] snap_x, snap_y, tmp_byte;
    logic [AW-1:0] a28;
    bit first_v, addr_bad, hold_bad, busy_bad, restarted;

    for (int i = 0; i < NBLK; i++) stall_plan[i] = 0;
    for (int i = 0; i < 20; i++) stall_plan[$urandom_range(3, NBLK-1)] = $urandom_range(1, 6);
    stall_plan[2] = 10;
    total = 0;
    for (int i = 0; i < NBLK; i++) total += stall_plan[i];
    limit = NBLK*BLK_CYC + 2 + total + 100;

    b = 0; wait_n = 0; rd_i = 0; cum = 0; done_cnt = 0; done_cyc = 0;
    first_v = 1'b1; addr_bad = 1'b0; hold_bad = 1'b0; busy_bad = 1'b0; restarted = 1'b0;
    snap_mcu = '0; snap_x = '0; snap_y = '0; a28 = '0;

    @(negedge clk); start = 1'b1; mcu_ready = 1'($urandom_range(0, 1)); cyc = 1;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        done_cnt++; done_cyc = cyc;
        checks++;
        if (busy !== 1'b0 || freeze_img !== 1'b0) begin
          errors++; $display("FAIL busy_at_done: got busy=%b freeze=%b expected 0 0", busy, freeze_img);
        end
        break;
      end
      if (b == 100 && !restarted && !mcu_valid) begin start = 1'b1; restarted = 1'b1; end
      if (busy !== 1'b1 || freeze_img !== 1'b1) busy_bad = 1'b1;
      if (pix_rd_en) begin
        if (int'(pix_rd_addr) != exp_addr(b, rd_i)) addr_bad = 1'b1;
        if (b == 28 && rd_i == 0) a28 = pix_rd_addr;
        rd_i++;
      end
      if (mcu_valid) begin
        if (first_v) begin
          exp_mcu = exp_block(b % NBX, b / NBX);
          checks++;
          if (blk_x !== 8'(b % NBX) || blk_y !== 8'(b / NBX)) begin
            errors++; $display("FAIL blk_idx: got (%0d,%0d) expected (%0d,%0d)", blk_x, blk_y, b % NBX, b / NBX);
          end
          checks++;
          if (mcu !== exp_mcu) begin
            errors++; $display("FAIL mcu_blk%0d: got %h expected %h", b, mcu, exp_mcu);
          end
          checks++;
          if (rd_i != 64 || addr_bad) begin
            errors++; $display("FAIL rd_seq_blk%0d: got %0d reads addr_bad=%0d expected 64 reads addr_bad=0", b, rd_i, addr_bad);
          end
          checks++;
          if (stall_cycles !== exp_stall(cum)) begin
            errors++; $display("FAIL stall_cnt_blk%0d: got %0d expected %0d", b, stall_cycles, exp_stall(cum));
          end
          if (b == 0) begin
            tmp_byte = mcu[79:72];
            checks++;
            if (tmp_byte !== ram[225]) begin errors++; $display("FAIL blk0_byte9: got %0h expected %0h", tmp_byte, ram[225]); end
          end
          if (b == 1) begin
            tmp_byte = mcu[7:0];
            checks++;
            if (tmp_byte !== ram[8]) begin errors++; $display("FAIL blk1_byte0: got %0h expected %0h", tmp_byte, ram[8]); end
          end
          if (b == 28) begin
            checks++;
            if (a28 !== AW'(1792) || blk_x !== 8'd0 || blk_y !== 8'd1) begin
              errors++; $display("FAIL row_wrap: got addr=%0d blk=(%0d,%0d) expected 1792 (0,1)", a28, blk_x, blk_y);
            end
          end
          snap_mcu = mcu; snap_x = blk_x; snap_y = blk_y;
          first_v = 1'b0;
        end else if (mcu !== snap_mcu || blk_x !== snap_x || blk_y !== snap_y) begin
          hold_bad = 1'b1;
        end
        if (wait_n < stall_plan[b]) begin
          mcu_ready = 1'b0; wait_n++;
        end else begin
          mcu_ready = 1'b1;
          cum += stall_plan[b];
          b++; wait_n = 0; rd_i = 0; first_v = 1'b1; addr_bad = 1'b0;
        end
      end else begin
        mcu_ready = 1'($urandom_range(0, 1));
      end
    end

    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_seen: got %0d pulses expected 1 within %0d cycles", done_cnt, limit); end
    checks++;
    if (done_cyc != NBLK*BLK_CYC + 2 + total) begin
      errors++; $display("FAIL done_latency: got cycle %0d expected %0d", done_cyc, NBLK*BLK_CYC + 2 + total);
    end
    checks++;
    if (b != NBLK) begin errors++; $display("FAIL block_count: got %0d expected %0d", b, NBLK); end
    checks++;
    if (hold_bad) begin errors++; $display("FAIL hold_stable: got mcu/blk change during stall expected stable"); end
    checks++;
    if (busy_bad) begin errors++; $display("FAIL busy_frame: got busy/freeze low mid-frame expected high"); end

    extra_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mcu_ready = 1'($urandom_range(0, 1));
      if (done) extra_done++;
    end
    checks++;
    if (extra_done != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL after_done: got extra_done=%0d busy=%b expected 0 0", extra_done, busy);
    end
    checks++;
    if (blk_x !== 8'(NBX-1) || blk_y !== 8'(NBY-1)) begin
      errors++; $display("FAIL last_blk_hold: got (%0d,%0d) expected (%0d,%0d)", blk_x, blk_y, NBX-1, NBY-1);
    end
    checks++;
    if (stall_cycles !== exp_stall(total)) begin
      errors++; $display("FAIL stall_final: got %0d expected %0d", stall_cycles, exp_stall(total));
    end
  endtask

  initial begin
    for (int a = 0; a < NPIX; a++) ram[a] = 8'(a % 251);
    test_reset;
    test_reset_mid_frame;
    test_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
